// File: rtl/firin.sv
// Oven controller: captures a dough description, then runs proofing, preheat and bake
// phases on down-counters. It holds bread-ready or error until the consumer acknowledges.
module firin #(
  parameter int MAYALANMA_SURE = 8,
  parameter int ON_ISITMA_SURE = 4,
  parameter int PISIRME_INCE   = 6,
  parameter int PISIRME_ORTA   = 10,
  parameter int PISIRME_KALIN  = 14
) (
  input  logic       saat,
  input  logic       reset,
  input  logic       hamur_hazir,
  input  logic [1:0] kalinlik,
  input  logic       mayali,
  input  logic       tuzlu,
  input  logic       alindi,
  output logic [2:0] durum,
  output logic [4:0] kalan_sure,
  output logic       isitici,
  output logic       mesgul,
  output logic       ekmek_hazir,
  output logic       hata,
  output logic [1:0] ekmek_kalinlik,
  output logic       tuzlu_ekmek
);

  typedef enum logic [2:0] {
    BOSTA     = 3'd0,
    MAYALANMA = 3'd1,
    ISITMA    = 3'd2,
    PISIRME   = 3'd3,
    HAZIR     = 3'd4,
    HATA      = 3'd5
  } durum_t;

  // Counter load values are duration minus one, so each state lasts exactly its duration.
  localparam logic [4:0] MAYA_YUK  = 5'(MAYALANMA_SURE - 1);
  localparam logic [4:0] ISIT_YUK  = 5'(ON_ISITMA_SURE - 1);
  localparam logic [4:0] INCE_YUK  = 5'(PISIRME_INCE - 1);
  localparam logic [4:0] ORTA_YUK  = 5'(PISIRME_ORTA - 1);
  localparam logic [4:0] KALIN_YUK = 5'(PISIRME_KALIN - 1);

  durum_t     state_q, state_d;
  logic [4:0] sayac_q, sayac_d;
  logic [1:0] kalinlik_q, kalinlik_d;
  logic       maya_q, maya_d;
  logic       tuzlu_q, tuzlu_d;
  logic [4:0] pisirme_yuk;

  always_comb begin
    pisirme_yuk = KALIN_YUK;
    case (kalinlik_q)
      2'd0:    pisirme_yuk = INCE_YUK;
      2'd1:    pisirme_yuk = ORTA_YUK;
      default: pisirme_yuk = KALIN_YUK;
    endcase
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      state_q    <= BOSTA;
      sayac_q    <= 5'd0;
      kalinlik_q <= 2'd0;
      maya_q     <= 1'b0;
      tuzlu_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sayac_q    <= sayac_d;
      kalinlik_q <= kalinlik_d;
      maya_q     <= maya_d;
      tuzlu_q    <= tuzlu_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sayac_d    = sayac_q;
    kalinlik_d = kalinlik_q;
    maya_d     = maya_q;
    tuzlu_d    = tuzlu_q;
    case (state_q)
      BOSTA: begin
        sayac_d = 5'd0;
        if (hamur_hazir) begin
          kalinlik_d = kalinlik;
          maya_d     = mayali;
          tuzlu_d    = tuzlu;
          if (kalinlik == 2'd3) begin
            state_d = HATA;
          end else if (mayali) begin
            state_d = MAYALANMA;
            sayac_d = MAYA_YUK;
          end else begin
            state_d = ISITMA;
            sayac_d = ISIT_YUK;
          end
        end
      end
      MAYALANMA: begin
        // An unyeasted loaf can never be proofing; leave at once if it somehow is.
        if (sayac_q == 5'd0 || !maya_q) begin
          state_d = ISITMA;
          sayac_d = ISIT_YUK;
        end else begin
          sayac_d = sayac_q - 5'd1;
        end
      end
      ISITMA: begin
        if (sayac_q == 5'd0) begin
          state_d = PISIRME;
          sayac_d = pisirme_yuk;
        end else begin
          sayac_d = sayac_q - 5'd1;
        end
      end
      PISIRME: begin
        if (sayac_q == 5'd0) begin
          state_d = HAZIR;
          sayac_d = 5'd0;
        end else begin
          sayac_d = sayac_q - 5'd1;
        end
      end
      HAZIR, HATA: begin
        sayac_d = 5'd0;
        // A same-edge dough request is dropped; it is taken later from BOSTA.
        if (alindi) begin
          state_d = BOSTA;
        end
      end
      default: begin
        state_d = BOSTA;
        sayac_d = 5'd0;
      end
    endcase
  end

  assign durum          = state_q;
  assign kalan_sure     = sayac_q;
  assign isitici        = (state_q == ISITMA) || (state_q == PISIRME);
  assign mesgul         = (state_q != BOSTA);
  assign ekmek_hazir    = (state_q == HAZIR);
  assign hata           = (state_q == HATA);
  assign ekmek_kalinlik = kalinlik_q;
  assign tuzlu_ekmek    = tuzlu_q;

endmodule

// File: tb/tb_firin.sv
// Bench for firin: table-driven loaves, directed corner sequences and random traffic.
// A schedule-queue reference model predicts every output after each edge.
module tb_firin;

  localparam int M  = 8;
  localparam int IS = 4;
  int bake_tbl [3] = '{6, 10, 14};

  logic       saat = 1'b0;
  logic       reset;
  logic       hamur_hazir;
  logic [1:0] kalinlik;
  logic       mayali;
  logic       tuzlu;
  logic       alindi;
  logic [2:0] durum;
  logic [4:0] kalan_sure;
  logic       isitici, mesgul, ekmek_hazir, hata, tuzlu_ekmek;
  logic [1:0] ekmek_kalinlik;

  int checks = 0;
  int errors = 0;

  firin dut (
    .saat(saat), .reset(reset), .hamur_hazir(hamur_hazir), .kalinlik(kalinlik),
    .mayali(mayali), .tuzlu(tuzlu), .alindi(alindi), .durum(durum),
    .kalan_sure(kalan_sure), .isitici(isitici), .mesgul(mesgul),
    .ekmek_hazir(ekmek_hazir), .hata(hata), .ekmek_kalinlik(ekmek_kalinlik),
    .tuzlu_ekmek(tuzlu_ekmek)
  );

  always #5 saat = ~saat;

  // Reference model: a captured loaf becomes a queue of (state, remaining) steps.
  typedef struct { int d; int k; } adim_t;
  adim_t sched[$];
  int    term;
  int    m_kal;
  int    m_tuz;

  function automatic int cur_d();
    return (sched.size() > 0) ? sched[0].d : term;
  endfunction

  function automatic int cur_k();
    return (sched.size() > 0) ? sched[0].k : 0;
  endfunction

  task automatic model_clear();
    sched.delete();
    term  = 0;
    m_kal = 0;
    m_tuz = 0;
  endtask

  task automatic model_step();
    if (sched.size() > 0) begin
      void'(sched.pop_front());
      if (sched.size() == 0) term = 4;
    end else if (term == 0 && hamur_hazir) begin
      m_kal = int'(kalinlik);
      m_tuz = int'(tuzlu);
      if (kalinlik == 2'd3) begin
        term = 5;
      end else begin
        if (mayali) for (int k = M - 1; k >= 0; k--) sched.push_back('{1, k});
        for (int k = IS - 1; k >= 0; k--) sched.push_back('{2, k});
        for (int k = bake_tbl[kalinlik] - 1; k >= 0; k--) sched.push_back('{3, k});
      end
    end else if ((term == 4 || term == 5) && alindi) begin
      term = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int d;
    d = cur_d();
    chk("durum", int'(durum), d);
    chk("kalan_sure", int'(kalan_sure), cur_k());
    chk("isitici", int'(isitici), int'(d == 2 || d == 3));
    chk("mesgul", int'(mesgul), int'(d != 0));
    chk("ekmek_hazir", int'(ekmek_hazir), int'(d == 4));
    chk("hata", int'(hata), int'(d == 5));
    chk("ekmek_kalinlik", int'(ekmek_kalinlik), m_kal);
    chk("tuzlu_ekmek", int'(tuzlu_ekmek), m_tuz);
  endtask

  task automatic tick();
    @(posedge saat);
    model_step();
    @(negedge saat);
    check_all();
  endtask

  task automatic idle_inputs();
    hamur_hazir = 1'b0; kalinlik = 2'd0; mayali = 1'b0; tuzlu = 1'b0; alindi = 1'b0;
  endtask

  // Called at a falling edge; asserts reset between edges and releases it before the next.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_clear();
    #1 check_all();
    #1 reset = 1'b0;
  endtask

  task automatic capture(input logic [1:0] k, input logic m, input logic t);
    kalinlik = k; mayali = m; tuzlu = t; hamur_hazir = 1'b1;
    tick();
    hamur_hazir = 1'b0;
  endtask

  typedef struct {
    logic [1:0] k; logic m; logic t;
    int lat; int n_maya; int n_isit; int n_pis; int n_heat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n, cnt_maya, cnt_isit, cnt_pis, cnt_heat;
    model_clear();
    idle_inputs();
    reset = 1'b1;
    #1 check_all();
    @(negedge saat);
    reset = 1'b0;
    tick();

    vecs[0] = '{2'd0, 1'b0, 1'b1, 10, 0, 4, 6, 10};
    vecs[1] = '{2'd2, 1'b1, 1'b0, 26, 8, 4, 14, 18};
    vecs[2] = '{2'd1, 1'b1, 1'b1, 22, 8, 4, 10, 14};
    vecs[3] = '{2'd1, 1'b0, 1'b0, 14, 0, 4, 10, 14};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 18, 8, 4, 6, 10};

    foreach (vecs[v]) begin
      capture(vecs[v].k, vecs[v].m, vecs[v].t);
      n = 0; cnt_maya = 0; cnt_isit = 0; cnt_pis = 0; cnt_heat = 0;
      while (!ekmek_hazir && n < 100) begin
        if (durum == 3'd1) cnt_maya++;
        if (durum == 3'd2) cnt_isit++;
        if (durum == 3'd3) cnt_pis++;
        if (isitici) cnt_heat++;
        tick();
        n++;
      end
      chk("latency", n, vecs[v].lat);
      chk("proof_cycles", cnt_maya, vecs[v].n_maya);
      chk("preheat_cycles", cnt_isit, vecs[v].n_isit);
      chk("bake_cycles", cnt_pis, vecs[v].n_pis);
      chk("heater_cycles", cnt_heat, vecs[v].n_heat);
      chk("latched_kal", int'(ekmek_kalinlik), int'(vecs[v].k));
      chk("latched_tuz", int'(tuzlu_ekmek), int'(vecs[v].t));
      repeat (3) begin
        tick();
        chk("ready_hold", int'(ekmek_hazir), 1);
      end
      alindi = 1'b1;
      tick();
      alindi = 1'b0;
      chk("ack_idle", int'(durum), 0);
      chk("kal_kept", int'(ekmek_kalinlik), int'(vecs[v].k));
      tick();
    end

    // Invalid dough
    capture(2'd3, 1'b1, 1'b1);
    chk("inv_durum", int'(durum), 5);
    chk("inv_hata", int'(hata), 1);
    repeat (4) begin
      tick();
      chk("inv_heater", int'(isitici), 0);
    end
    alindi = 1'b1;
    tick();
    alindi = 1'b0;
    chk("inv_ack", int'(durum), 0);

    // Busy oven: a second request during bake is ignored
    capture(2'd2, 1'b0, 1'b1);
    n = 0;
    while (durum != 3'd3 && n < 50) begin tick(); n++; end
    chk("reach_bake", int'(durum), 3);
    kalinlik = 2'd1; hamur_hazir = 1'b1;
    tick();
    hamur_hazir = 1'b0; kalinlik = 2'd0;
    chk("busy_kal", int'(ekmek_kalinlik), 2);
    n = 0;
    while (!ekmek_hazir && n < 50) begin tick(); n++; end
    chk("busy_done", int'(ekmek_hazir), 1);
    chk("busy_kal_end", int'(ekmek_kalinlik), 2);

    // Acknowledge and new dough on the same edge
    alindi = 1'b1; hamur_hazir = 1'b1; kalinlik = 2'd1; mayali = 1'b0; tuzlu = 1'b0;
    tick();
    alindi = 1'b0;
    chk("simul_idle", int'(durum), 0);
    chk("simul_nocap", int'(ekmek_kalinlik), 2);
    tick();
    hamur_hazir = 1'b0;
    chk("simul_cap", int'(durum), 2);
    chk("simul_kal", int'(ekmek_kalinlik), 1);

    // Reset mid-proofing at kalan_sure=5
    async_reset();
    tick();
    capture(2'd2, 1'b1, 1'b1);
    n = 0;
    while (kalan_sure != 5'd5 && n < 20) begin tick(); n++; end
    chk("pre_rst_durum", int'(durum), 1);
    chk("pre_rst_kalan", int'(kalan_sure), 5);
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("rst_out", int'({durum, kalan_sure, isitici, mesgul, ekmek_hazir, hata,
                         ekmek_kalinlik, tuzlu_ekmek}), 0);
    check_all();
    #1 reset = 1'b0;
    repeat (5) begin
      tick();
      chk("post_rst_idle", int'(durum), 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      hamur_hazir = ($urandom_range(0, 3) == 0);
      kalinlik    = 2'($urandom_range(0, 3));
      mayali      = 1'($urandom_range(0, 1));
      tuzlu       = 1'($urandom_range(0, 1));
      alindi      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
